move_zero: RTL and testbench
============================

# move_zero

Moves the blank tile (value 0) of a 4x4 sliding-tile (Klotski) board to a target cell along a shortest path that never disturbs locked cells. It is a step engine inside the klotski solver. The solver hands it a board, a lock mask and a target, and gets back the rearranged board plus a done strobe. The path is found by an iterative breadth-first distance map, then walked one swap per clock.

## Interface
- No parameters.
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle request; sampled only in IDLE.
- i_flag  in  1  tie-break: 0 = prefer row moves, 1 = prefer column moves.
- i_klotski  in  [3:0][3:0][3:0]  board; [r][c] is a 4-bit tile, 0 = blank.
- i_mask  in  [3:0][3:0]  [r][c]=1 locks that cell; the blank never enters it.
- i_target  in  [1:0][1:0]  [1] = target row, [0] = target column.
- o_klotski  out  [3:0][3:0][3:0]  working board register.
- o_finished  out  1  high for exactly one cycle when done.

## Operation
- States: IDLE, DIST, MOVE, DONE.
- IDLE + i_start:
  - Latch board, mask and target.
  - Locate the blank. If there are several zeros, use the lowest index (r*4+c).
  - Init the 5-bit distance map: target = 0, all others = 31 (infinity).
  - Go to DIST.
- DIST relaxation, one step per cycle, for every unmasked cell: dist = min(dist, 1 + min of the 4-neighbour dists).
  - Masked cells stay 31. A masked target is still seeded 0.
  - Saturate at 31.
  - After 15 iterations, go to MOVE.
- MOVE, each cycle:
  - If blank == target, go to DONE.
  - Else, if dist(blank) == 31 (unreachable), go to DONE with the board unchanged.
  - Else swap the blank with the first neighbour whose dist == dist(blank) − 1, and update the blank position.
  - Neighbour priority, i_flag=0: row−1, row+1, col−1, col+1.
  - Neighbour priority, i_flag=1: col−1, col+1, row−1, row+1.
  - i_flag is sampled live.
- DONE: o_finished=1, then go to IDLE. o_klotski holds until the next start.
- i_start outside IDLE is ignored.
- Tiles at masked positions are never moved.

## Timing
- Reset (any time, including mid-operation): state IDLE, o_klotski = 0, o_finished = 0, distance map = 31.
- Start edge E0 loads the request.
- DIST occupies E1..E15.
- Each MOVE edge performs one swap. N swaps take N+1 MOVE edges.
- o_finished is high for one cycle, (15 + N + 2) cycles after E0.
- Blank already at target: o_finished occurs 17 cycles after E0.
- o_klotski changes only on the load edge and on swap edges.

## Configuration
- MOVE_ZERO_EARLY_EXIT_EN:
  - Defined: DIST exits to MOVE on the first iteration that changes no distance (max 15 iterations). Latency shrinks accordingly.
  - Undefined: always exactly 15 DIST iterations, fully deterministic latency.

## Structure
- Package move_zero_pkg holds:
  - board_t [3:0][3:0][3:0]
  - mask_t [3:0][3:0]
  - pos_t {row, col} 2+2 bits
  - dist_t 5 bits
  - DIST_INF = 31
  - DIST_ITERS = 15
  - state enum
- Sub-module move_zero_relax: combinational single relaxation step, distance map plus mask in, new map plus changed flag out.
- Top level holds the FSM, blank tracker, neighbour selector and swap logic.

## Test plan
- Board rows r3..r0 = {10,1,14,12},{6,2,9,15},{3,7,5,4},{0,11,8,13}, i.e. blank at [0][3]. Locks at [2][2] and [1][3]. Target (0,0), i_flag=0.
  - 3 swaps.
  - Row 0 becomes {11,8,13,0}; other rows unchanged.
  - o_finished pulses 20 cycles after start.
- Same board, target (0,3) -> no swaps, board unchanged, o_finished at 17 cycles.
- Blank at [0][0], target (3,3), no mask, i_flag=0 vs 1 -> 6 swaps each.
  - Flag 0 walks rows first, flag 1 walks columns first.
  - Final blank at [3][3] in both cases.
- Blank at [0][0], cells [0][1] and [1][0] locked, target (3,3) -> unreachable, board unchanged, o_finished at 17 cycles.
- Assert i_rst mid-MOVE -> o_klotski = 0 and o_finished = 0 immediately. A fresh start then completes normally.
- i_start pulsed during DIST -> ignored, and the original run completes with unchanged timing.

Source files
------------

// File: rtl/move_zero_pkg.sv
// Shared types and constants for the move_zero blank-tile step engine.
package move_zero_pkg;

  typedef logic [3:0][3:0][3:0] board_t;
  typedef logic [3:0][3:0]      mask_t;
  typedef logic [4:0]           dist_t;
  typedef dist_t [3:0][3:0]     dmap_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } pos_t;

  localparam dist_t DIST_INF   = 5'd31;
  localparam int    DIST_ITERS = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIST = 2'd1,
    MOVE = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/move_zero_relax.sv
// One combinational breadth-first relaxation step over the 4x4 distance map.
module move_zero_relax
  import move_zero_pkg::*;
(
  input  dmap_t dist_i,
  input  mask_t mask_i,
  output dmap_t dist_o,
  output logic  changed_o
);

  function automatic dist_t dmin(input dist_t a, input dist_t b);
    return (a < b) ? a : b;
  endfunction

  logic [15:0] chg;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      dist_t      up, dn, lf, rt, best, relaxed;
      logic [5:0] cand;

      if (r > 0) begin : g_up
        assign up = dist_i[r-1][c];
      end else begin : g_up_edge
        assign up = DIST_INF;
      end
      if (r < 3) begin : g_dn
        assign dn = dist_i[r+1][c];
      end else begin : g_dn_edge
        assign dn = DIST_INF;
      end
      if (c > 0) begin : g_lf
        assign lf = dist_i[r][c-1];
      end else begin : g_lf_edge
        assign lf = DIST_INF;
      end
      if (c < 3) begin : g_rt
        assign rt = dist_i[r][c+1];
      end else begin : g_rt_edge
        assign rt = DIST_INF;
      end

      assign best    = dmin(dmin(up, dn), dmin(lf, rt));
      assign cand    = {1'b0, best} + 6'd1;
      assign relaxed = (cand > {1'b0, DIST_INF}) ? DIST_INF : cand[4:0];
      // Locked cells keep their value, so a locked target stays at its seed of 0.
      assign dist_o[r][c] = mask_i[r][c] ? dist_i[r][c] : dmin(dist_i[r][c], relaxed);
      assign chg[r*4+c]   = (dist_o[r][c] != dist_i[r][c]);
    end
  end

  assign changed_o = |chg;

endmodule

// File: rtl/move_zero.sv
// Blank-tile mover: BFS distance map then one swap per clock toward the target.
// Optional build macro MOVE_ZERO_EARLY_EXIT_EN ends the distance phase once the map is stable.
module move_zero
  import move_zero_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flag,
  input  board_t          i_klotski,
  input  mask_t           i_mask,
  input  logic [1:0][1:0] i_target,
  output board_t          o_klotski,
  output logic            o_finished
);

  state_t     state_q, state_d;
  board_t     board_q, board_d;
  mask_t      mask_q, mask_d;
  pos_t       target_q, target_d;
  pos_t       blank_q, blank_d;
  dmap_t      dist_q, dist_d;
  logic [3:0] iter_q, iter_d;
  logic       fin_q, fin_d;

  dmap_t      dist_relaxed;
  logic       changed;
  logic       dist_exit;
  dist_t      d_cur;
  pos_t [3:0] nb_pos;
  logic [3:0] nb_ok;
  logic [1:0] dir;
  logic       found;
  pos_t       nb_sel;
  pos_t       blank_init;

  move_zero_relax u_relax (
    .dist_i   (dist_q),
    .mask_i   (mask_q),
    .dist_o   (dist_relaxed),
    .changed_o(changed)
  );

`ifdef MOVE_ZERO_EARLY_EXIT_EN
  assign dist_exit = (iter_q == 4'd1) || !changed;
`else
  logic unused_changed;
  assign unused_changed = changed;
  assign dist_exit      = (iter_q == 4'd1);
`endif

  // Scan high to low so the lowest-index zero wins.
  always_comb begin
    blank_init = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i_klotski[i/4][i%4] == 4'd0) begin
        blank_init.row = 2'(i / 4);
        blank_init.col = 2'(i % 4);
      end
    end
  end

  // Directions: 0 row-1, 1 row+1, 2 col-1, 3 col+1.
  always_comb begin
    d_cur         = dist_q[blank_q.row][blank_q.col];
    nb_pos[0].row = blank_q.row - 2'd1;
    nb_pos[0].col = blank_q.col;
    nb_pos[1].row = blank_q.row + 2'd1;
    nb_pos[1].col = blank_q.col;
    nb_pos[2].row = blank_q.row;
    nb_pos[2].col = blank_q.col - 2'd1;
    nb_pos[3].row = blank_q.row;
    nb_pos[3].col = blank_q.col + 2'd1;
    nb_ok[0]      = (blank_q.row != 2'd0);
    nb_ok[1]      = (blank_q.row != 2'd3);
    nb_ok[2]      = (blank_q.col != 2'd0);
    nb_ok[3]      = (blank_q.col != 2'd3);
    for (int k = 0; k < 4; k++) begin
      nb_ok[k] = nb_ok[k] && !mask_q[nb_pos[k].row][nb_pos[k].col]
                 && (dist_q[nb_pos[k].row][nb_pos[k].col] == d_cur - 5'd1);
    end
    found  = 1'b0;
    nb_sel = blank_q;
    dir    = '0;
    for (int k = 0; k < 4; k++) begin
      dir = i_flag ? 2'(k + 2) : 2'(k);
      if (!found && nb_ok[dir]) begin
        found  = 1'b1;
        nb_sel = nb_pos[dir];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    mask_d   = mask_q;
    target_d = target_q;
    blank_d  = blank_q;
    dist_d   = dist_q;
    iter_d   = iter_q;
    fin_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          board_d      = i_klotski;
          mask_d       = i_mask;
          target_d.row = i_target[1];
          target_d.col = i_target[0];
          blank_d      = blank_init;
          dist_d       = {16{DIST_INF}};
          dist_d[i_target[1]][i_target[0]] = '0;
          iter_d       = 4'(DIST_ITERS);
          state_d      = DIST;
        end
      end
      DIST: begin
        dist_d = dist_relaxed;
        iter_d = iter_q - 4'd1;
        if (dist_exit) state_d = MOVE;
      end
      MOVE: begin
        if (blank_q == target_q || d_cur == DIST_INF || !found) begin
          state_d = DONE;
        end else begin
          board_d[blank_q.row][blank_q.col] = board_q[nb_sel.row][nb_sel.col];
          board_d[nb_sel.row][nb_sel.col]   = board_q[blank_q.row][blank_q.col];
          blank_d = nb_sel;
        end
      end
      DONE: begin
        fin_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      board_q  <= '0;
      mask_q   <= '0;
      target_q <= '0;
      blank_q  <= '0;
      dist_q   <= {16{DIST_INF}};
      iter_q   <= '0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      mask_q   <= mask_d;
      target_q <= target_d;
      blank_q  <= blank_d;
      dist_q   <= dist_d;
      iter_q   <= iter_d;
      fin_q    <= fin_d;
    end
  end

  assign o_klotski  = board_q;
  assign o_finished = fin_q;

endmodule

// File: tb/tb_move_zero.sv
// Self-checking bench for move_zero: vector table, scoreboard queue, reset and busy-start sequences.
module tb_move_zero;
  import move_zero_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flag;
  board_t          kl;
  mask_t           mask;
  logic [1:0][1:0] tgt;
  board_t          okl;
  logic            fin;

  always #5 clk = ~clk;

  move_zero dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_flag    (flag),
    .i_klotski (kl),
    .i_mask    (mask),
    .i_target  (tgt),
    .o_klotski (okl),
    .o_finished(fin)
  );

  typedef struct {
    board_t     brd;
    mask_t      msk;
    logic [1:0] tr;
    logic [1:0] tc;
    logic       flg;
    board_t     exp_brd;
    int         exp_lat;
    int         exp_sw;
  } vec_t;

  typedef struct {
    board_t brd;
    int     lat;
    int     sw;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic board_t seq_board();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = 4'(r * 4 + c);
    return b;
  endfunction

  task automatic run_case(input vec_t v, input int glitch, input string tag);
    board_t prev;
    exp_t   e;
    int     cyc, sw;
    logic   got;
    @(negedge clk);
    kl     = v.brd;
    mask   = v.msk;
    tgt[1] = v.tr;
    tgt[0] = v.tc;
    flag   = v.flg;
    start  = 1'b1;
    sb.push_back('{v.exp_brd, v.exp_lat, v.exp_sw});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    prev  = okl;
    cyc   = 0;
    sw    = 0;
    got   = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (glitch > 0 && cyc == glitch) begin
        start  = 1'b1;
        kl     = seq_board();
        mask   = '0;
        tgt[1] = 2'd0;
        tgt[0] = 2'd3;
      end else begin
        start = 1'b0;
      end
      if (okl !== prev) sw++;
      prev = okl;
      if (fin) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_finish required=finish_within_60", tag);
      sb.delete();
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
      check({tag, "_board"}, okl, e.brd);
      check({tag, "_swaps"}, 64'(sw), 64'(e.sw));
      @(negedge clk);
      check({tag, "_fin_pulse"}, 64'(fin), 64'd0);
    end
  endtask

  initial begin
    board_t b;
    mask_t  m;
    int     saw;

    rst   = 1'b1;
    start = 1'b0;
    flag  = 1'b0;
    kl    = '0;
    mask  = '0;
    tgt   = '0;

    // Test-plan board and locks.
    b = {4'd10, 4'd1, 4'd14, 4'd12,  4'd6, 4'd2, 4'd9, 4'd15,
         4'd3,  4'd7, 4'd5,  4'd4,   4'd0, 4'd11, 4'd8, 4'd13};
    m = '0;
    m[2][2] = 1'b1;
    m[1][3] = 1'b1;
    vecs[0] = '{b, m, 2'd0, 2'd0, 1'b0,
                {b[3], b[2], b[1], 4'd11, 4'd8, 4'd13, 4'd0}, 20, 3};
    vecs[1] = '{b, m, 2'd0, 2'd3, 1'b0, b, 17, 0};

    b = seq_board();
    vecs[2] = '{b, '0, 2'd3, 2'd3, 1'b0, b, 23, 6};
    vecs[2].exp_brd[0][0] = 4'd4;
    vecs[2].exp_brd[1][0] = 4'd8;
    vecs[2].exp_brd[2][0] = 4'd12;
    vecs[2].exp_brd[3][0] = 4'd13;
    vecs[2].exp_brd[3][1] = 4'd14;
    vecs[2].exp_brd[3][2] = 4'd15;
    vecs[2].exp_brd[3][3] = 4'd0;
    vecs[3] = '{b, '0, 2'd3, 2'd3, 1'b1, b, 23, 6};
    vecs[3].exp_brd[0][0] = 4'd1;
    vecs[3].exp_brd[0][1] = 4'd2;
    vecs[3].exp_brd[0][2] = 4'd3;
    vecs[3].exp_brd[0][3] = 4'd7;
    vecs[3].exp_brd[1][3] = 4'd11;
    vecs[3].exp_brd[2][3] = 4'd15;
    vecs[3].exp_brd[3][3] = 4'd0;
    m = '0;
    m[0][1] = 1'b1;
    m[1][0] = 1'b1;
    vecs[4] = '{b, m, 2'd3, 2'd3, 1'b0, b, 17, 0};

    #1;
    check("reset_board", okl, 64'd0);
    check("reset_finished", 64'(fin), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_case(vecs[i], 0, $sformatf("vec%0d", i));

    // A start pulse during DIST must be ignored and leave timing intact.
    run_case(vecs[0], 5, "busy_start");

    // Reset in the middle of the swap phase.
    @(negedge clk);
    kl     = vecs[2].brd;
    mask   = vecs[2].msk;
    tgt[1] = vecs[2].tr;
    tgt[0] = vecs[2].tc;
    flag   = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midmove_rst_board", okl, 64'd0);
    check("midmove_rst_finished", 64'(fin), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (25) begin
      @(negedge clk);
      if (fin) saw++;
    end
    check("no_finish_after_rst", 64'(saw), 64'd0);
    check("board_held_after_rst", okl, 64'd0);

    run_case(vecs[2], 0, "after_rst");
    run_case(vecs[3], 0, "after_rst_flag1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
